// File: rtl/ext_pipe.sv
// Two-stage pipelined immediate extender for the ID stage.
// S1 holds the raw immediate and mode; S2 holds the extended operand that drives the outputs.
module ext_pipe #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [1:0]       busy_cnt
);

    // Wide immediates keep only their low half for LUI so the result still fits.
    localparam int LUI_W  = (IN_W > OUT_W / 2) ? OUT_W / 2 : IN_W;
    localparam int LUI_SH = OUT_W - LUI_W;

    localparam logic [2:0] M_ZERO   = 3'd0;
    localparam logic [2:0] M_SIGN   = 3'd1;
    localparam logic [2:0] M_LUI    = 3'd2;
    localparam logic [2:0] M_BRANCH = 3'd3;
    localparam logic [2:0] M_SHAMT  = 3'd4;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
    logic [2:0]       s1_mode_q, s1_mode_d;
    logic [OUT_W-1:0] s2_data_q, s2_data_d;
    logic             s2_err_q, s2_err_d;
    logic [1:0]       busy_cnt_q, busy_cnt_d;

    logic             s2_adv;
    logic             s1_load;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] f_data;
    logic             f_err;

    always_comb begin
        s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_adv;
        s1_load  = in_valid & in_ready;
    end

    always_comb begin
        zext   = OUT_W'(s1_imm_q);
        sext   = {{(OUT_W - IN_W){s1_imm_q[IN_W-1]}}, s1_imm_q};
        f_data = '0;
        f_err  = 1'b0;
        case (s1_mode_q)
            M_ZERO:   f_data = zext;
            M_SIGN:   f_data = sext;
            M_LUI:    f_data = zext << LUI_SH;
            M_BRANCH: f_data = sext << 2;
            M_SHAMT:  f_data = OUT_W'(s1_imm_q[SHAMT_W-1:0]);
            default:  f_err  = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_mode_d  = s1_mode_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_imm_d   = imm;
            s1_mode_d  = mode;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = f_data;
            s2_err_d   = f_err;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        busy_cnt_d = {1'b0, s1_valid_d} + {1'b0, s2_valid_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_mode_q  <= '0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_mode_q  <= s1_mode_d;
            s2_data_q  <= s2_data_d;
            s2_err_q   <= s2_err_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_err   = s2_err_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the ID stage. It is the successor to the single-mode combinational zero/sign extender.
- Takes an IN_W-bit immediate plus a mode select and produces an OUT_W-bit operand: zero-extended, sign-extended, LUI-shifted, branch-offset (sign-extended then shifted left 2) or shift-amount.
- Two register stages with valid/ready handshake at both sides, so it can sit between the decoder and the ID/EX latch under stalls.

Parameters:
IN_W, 16, immediate input width; legal range 5..OUT_W-2
OUT_W, 32, extended output width; must be greater than IN_W+1
SHAMT_W, 5, number of low immediate bits used in SHAMT mode; must be no greater than IN_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  imm/mode are valid this cycle
in_ready  out  1  unit accepts a transfer this cycle
imm  in  IN_W  raw immediate field
mode  in  3  0=ZERO, 1=SIGN, 2=LUI, 3=BRANCH, 4=SHAMT, 5..7 illegal
out_valid  out  1  out_data/out_err valid
out_ready  in  1  consumer accepts out_data
out_data  out  OUT_W  extended result
out_err  out  1  result came from an illegal mode
busy_cnt  out  2  number of occupied stages (0..2)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); all state clears immediately on assertion, independent of clk.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_err=0, busy_cnt=0.
- Stage 1 (S1) registers imm and mode.
- Stage 2 (S2) registers the computed result; out_data and out_err come directly from S2 registers.
- A transfer happens on a rising edge when valid and ready are both high, on either side.
- s2_adv = s1_valid & (~s2_valid | out_ready).
- in_ready = ~s1_valid | s2_adv. It is combinational and never depends on in_valid.
- S1 load: when in_valid & in_ready, S1 takes imm/mode and s1_valid=1. Otherwise, if s2_adv, s1_valid=0.
- S2 load: when s2_adv, S2 takes f(S1) and s2_valid=1. Otherwise, if out_ready, s2_valid=0.
- out_valid = s2_valid. Latency from input transfer to out_valid is exactly 2 cycles with no stalls. Sustained throughput is 1 result per clock.
- Stall: while out_valid & ~out_ready, out_data/out_err hold stable. S1 may still fill once, then in_ready=0.
- Simultaneous events: with S1 full, S2 full and out_ready=1 in one cycle, the output drains, S1 moves to S2 and a new input loads S1. No bubble, no loss, no duplication.
- f(imm, mode):
  - ZERO: {0, imm}.
  - SIGN: replicate imm[IN_W-1] into the upper bits.
  - LUI: imm placed at bits [OUT_W-1 : OUT_W-IN_W], low bits 0. If IN_W > OUT_W/2, take the low OUT_W/2 bits of imm instead.
  - BRANCH: sign-extend imm to OUT_W, then shift left 2 (the top 2 bits are lost; no overflow flag).
  - SHAMT: {0, imm[SHAMT_W-1:0]}.
  - Illegal mode: out_data=0, out_err=1.
  - out_err=0 for all legal modes.
- busy_cnt = s1_valid + s2_valid, registered with the stages.
- Payload registers change only on a load. An unused stage keeps its old data, but valid=0 masks it.
- in_valid may be deasserted at any time. imm/mode are sampled only on a transfer edge.
- Reset mid-operation: in-flight entries are discarded and out_valid drops asynchronously. After release, the first accepted input produces a result 2 cycles later.

Test Plan:
- Defaults, out_ready=1; send imm=16'hFFF8 in SIGN then ZERO on back-to-back cycles -> out_data=32'hFFFFFFF8 then 32'h0000FFF8, 2 cycles after each transfer, consecutive cycles.
- LUI imm=16'h1234 -> 32'h12340000. BRANCH imm=16'hFFFF -> 32'hFFFFFFFC. BRANCH imm=16'h7FFF -> 32'h0001FFFC. SHAMT imm=16'hFFF8 -> 32'h00000018. All with out_err=0.
- mode=7, imm=16'hABCD -> out_data=0, out_err=1. The next legal-mode transfer returns out_err=0.
- Hold out_ready=0 while streaming SIGN imm=1,2,3 -> after 2 accepts in_ready=0, busy_cnt=2, out_data=1 held. Raise out_ready -> results 1,2,3 in order, none dropped or duplicated, in_ready re-asserts the same cycle.
- Pulse rst_n low between clock edges while busy_cnt=2 -> out_valid and busy_cnt go 0 immediately. After release, new input SIGN 16'h8000 -> 32'hFFFF8000 after 2 cycles.
- Instance IN_W=5, OUT_W=32: imm=5'b11000 in SIGN -> 32'hFFFFFFF8, in ZERO -> 32'h00000018.
